// File: rtl/mcntrl_wbuf_sched_if.sv
// Producer/sequencer/buffer control bundle of the write-buffer page scheduler.
// The slave modport is the scheduler side; the master modport is the environment side.
interface mcntrl_wbuf_sched_if;
    logic       frame_start;
    logic       wpage_done;
    logic [1:0] wpage;
    logic       buf_full;
    logic [2:0] pages_ready;
    logic       xfer_want;
    logic       xfer_grant;
    logic       xfer_rd;
    logic       rd;
    logic       page_next;
    logic       rpage_set;
    logic [1:0] rpage_in;
    logic       xfer_busy;
    logic       xfer_done;
    logic       wbuf_ovf;

    modport slave (
        input  frame_start, wpage_done, xfer_grant, xfer_rd,
        output wpage, buf_full, pages_ready, xfer_want, rd, page_next,
               rpage_set, rpage_in, xfer_busy, xfer_done, wbuf_ovf
    );

    modport master (
        output frame_start, wpage_done, xfer_grant, xfer_rd,
        input  wpage, buf_full, pages_ready, xfer_want, rd, page_next,
               rpage_set, rpage_in, xfer_busy, xfer_done, wbuf_ovf
    );
endinterface

// File: rtl/mcntrl_wbuf_sched.sv
// Page scheduler for the 4-page external-write buffer of a memory controller write channel.
// Optional sticky overflow flag: define MCNTRL_WBUF_SCHED_OVF_EN to build it.
module mcntrl_wbuf_sched #(
    parameter int PAGE_WORDS = 128
) (
    input  logic               mclk,
    input  logic               mrst_n,
    mcntrl_wbuf_sched_if.slave bus
);
    localparam int WCNT_W = $clog2(PAGE_WORDS) + 1;
    localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(PAGE_WORDS);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(PAGE_WORDS - 1);

    if (PAGE_WORDS < 2 || (PAGE_WORDS & (PAGE_WORDS - 1)) != 0) begin : g_bad_param
        $error("PAGE_WORDS must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          wptr_q, wptr_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                rpage_set_q, rpage_set_d;

    logic                wr_acc;
    logic                rd_gate;
    logic                want_o, busy_o, done_o;

    assign wr_acc = bus.wpage_done & (cnt_q != 3'd4);

    // FSM state register
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; frame_start overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cnt_q != 3'd0) state_d = S_REQ;
            S_REQ:  if (bus.xfer_grant) state_d = S_XFER;
            S_XFER: if (rd_gate && (wcnt_q == WCNT_LAST)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.frame_start) state_d = S_IDLE;
    end

    // FSM outputs
    always_comb begin
        want_o  = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        rd_gate = 1'b0;
        case (state_q)
            S_REQ: begin
                want_o = 1'b1;
                busy_o = 1'b1;
            end
            S_XFER: begin
                busy_o  = 1'b1;
                rd_gate = bus.xfer_rd & (wcnt_q < WCNT_FULL);
            end
            S_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Page bookkeeping; a write and a completion in the same cycle cancel in cnt
    always_comb begin
        wptr_d      = wptr_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        rpage_set_d = 1'b0;

        if (wr_acc) wptr_d = wptr_q + 2'd1;

        if (wr_acc && !done_o) begin
            cnt_d = cnt_q + 3'd1;
        end else if (!wr_acc && done_o) begin
            cnt_d = cnt_q - 3'd1;
        end

        if (done_o) begin
            wcnt_d = '0;
        end else if (rd_gate) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
        end

        if (bus.frame_start) begin
            wptr_d      = 2'd0;
            cnt_d       = 3'd0;
            wcnt_d      = '0;
            rpage_set_d = 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            wptr_q      <= 2'd0;
            cnt_q       <= 3'd0;
            wcnt_q      <= '0;
            rpage_set_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            rpage_set_q <= rpage_set_d;
        end
    end

`ifdef MCNTRL_WBUF_SCHED_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky until the next frame; a same-cycle completion does not excuse the drop
    always_comb begin
        ovf_d = ovf_q;
        if (bus.frame_start) begin
            ovf_d = 1'b0;
        end else if (bus.wpage_done && (cnt_q == 3'd4)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.wbuf_ovf = ovf_q;
`else
    assign bus.wbuf_ovf = 1'b0;
`endif

    assign bus.wpage       = wptr_q;
    assign bus.buf_full    = (cnt_q == 3'd4);
    assign bus.pages_ready = cnt_q;
    assign bus.xfer_want   = want_o;
    assign bus.rd          = rd_gate;
    assign bus.page_next   = done_o & ~rpage_set_q;
    assign bus.xfer_done   = done_o;
    assign bus.rpage_set   = rpage_set_q;
    assign bus.rpage_in    = 2'd0;
    assign bus.xfer_busy   = busy_o;

endmodule

// File: tb/tb_mcntrl_wbuf_sched.sv
// Directed bench for mcntrl_wbuf_sched: page-level reference model compared every cycle,
// plus hand-computed expectations for each scenario.
module tb_mcntrl_wbuf_sched;
    localparam int PW = 128;
`ifdef MCNTRL_WBUF_SCHED_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic mclk   = 1'b0;
    logic mrst_n = 1'b0;

    mcntrl_wbuf_sched_if bus ();

    mcntrl_wbuf_sched #(.PAGE_WORDS(PW)) dut (
        .mclk  (mclk),
        .mrst_n(mrst_n),
        .bus   (bus)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt = 0, pn_cnt = 0, xd_cnt = 0, rs_cnt = 0;
    int pn_cyc[$];

    // Reference model: pending pages, write pointer and the current page's progress
    int   m_cnt, m_wptr, m_left;
    logic m_want, m_fin, m_rs, m_ovf;

    always @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            m_cnt <= 0; m_wptr <= 0; m_left <= 0;
            m_want <= 1'b0; m_fin <= 1'b0; m_rs <= 1'b0; m_ovf <= 1'b0;
        end else if (bus.frame_start) begin
            m_cnt <= 0; m_wptr <= 0; m_left <= 0;
            m_want <= 1'b0; m_fin <= 1'b0; m_rs <= 1'b1; m_ovf <= 1'b0;
        end else begin
            m_rs <= 1'b0;
            if (bus.wpage_done && m_cnt < 4) m_wptr <= (m_wptr + 1) % 4;
            m_cnt <= m_cnt + ((bus.wpage_done && m_cnt < 4) ? 1 : 0) - (m_fin ? 1 : 0);
            if (bus.wpage_done && m_cnt == 4 && OVF) m_ovf <= 1'b1;
            m_fin <= (m_left == 1) && bus.xfer_rd;
            if (m_left > 0 && bus.xfer_rd) m_left <= m_left - 1;
            else if (m_want && bus.xfer_grant) m_left <= PW;
            m_want <= m_want ? !bus.xfer_grant : (!m_fin && m_left == 0 && m_cnt != 0);
        end
    end

    always @(posedge mclk) cyc <= cyc + 1;

    function automatic logic [14:0] dut_vec();
        return {bus.wpage, bus.buf_full, bus.pages_ready, bus.xfer_want, bus.rd,
                bus.page_next, bus.rpage_set, bus.rpage_in, bus.xfer_busy,
                bus.xfer_done, bus.wbuf_ovf};
    endfunction

    function automatic logic [14:0] model_vec();
        logic busy;
        busy = m_want || (m_left > 0) || m_fin;
        return {2'(m_wptr), (m_cnt == 4), 3'(m_cnt), m_want,
                ((m_left > 0) && bus.xfer_rd), m_fin, m_rs, 2'b00, busy,
                m_fin, m_ovf};
    endfunction

    always @(negedge mclk) begin
        if (mrst_n) begin
            logic [14:0] a, e;
            a = dut_vec();
            e = model_vec();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t: got %b required %b", $time, a, e);
            end
            if (bus.rd === 1'b1) rd_cnt++;
            if (bus.xfer_done === 1'b1) xd_cnt++;
            if (bus.rpage_set === 1'b1) rs_cnt++;
            if (bus.page_next === 1'b1) begin
                pn_cnt++;
                pn_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic clr_cnt();
        rd_cnt = 0; pn_cnt = 0; xd_cnt = 0; rs_cnt = 0;
        pn_cyc.delete();
    endtask

    // Starts in REQ, ends positioned in the DONE cycle
    task automatic xfer_page();
        bus.xfer_grant = 1'b1;
        tick();
        bus.xfer_grant = 1'b0;
        bus.xfer_rd = 1'b1;
        tick(PW);
        bus.xfer_rd = 1'b0;
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.wpage_done  = 1'b0;
        bus.xfer_grant  = 1'b0;
        bus.xfer_rd     = 1'b0;
        tick(3);
        chk("reset_outputs", 16'(dut_vec()), 16'd0);
        mrst_n = 1'b1;
        tick();

        // Single page
        bus.wpage_done = 1'b1;
        tick();
        bus.wpage_done = 1'b0;
        chk("want_after_1_edge", 16'(bus.xfer_want), 16'd0);
        tick();
        chk("want_after_2_edges", 16'(bus.xfer_want), 16'd1);
        clr_cnt();
        xfer_page();
        chk("single_done_pulse", 16'(bus.xfer_done), 16'd1);
        tick(3);
        chk("single_rd_count", 16'(rd_cnt), 16'd128);
        chk("single_page_next", 16'(pn_cnt), 16'd1);
        chk("single_xfer_done", 16'(xd_cnt), 16'd1);
        chk("single_ready", 16'(bus.pages_ready), 16'd0);
        chk("single_wpage", 16'(bus.wpage), 16'd1);

        // Strobes outside XFER and beyond the page
        clr_cnt();
        bus.xfer_rd = 1'b1;
        tick(3);
        bus.wpage_done = 1'b1;
        tick();
        bus.wpage_done = 1'b0;
        tick(3);
        chk("rd_idle_req", 16'(rd_cnt), 16'd0);
        bus.xfer_grant = 1'b1;
        tick();
        bus.xfer_grant = 1'b0;
        tick(130);
        bus.xfer_rd = 1'b0;
        tick();
        chk("excess_rd_count", 16'(rd_cnt), 16'd128);
        chk("excess_page_next", 16'(pn_cnt), 16'd1);
        chk("excess_wpage", 16'(bus.wpage), 16'd2);

        // Frame restart from idle
        clr_cnt();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("restart_rpage_set", 16'(bus.rpage_set), 16'd1);
        tick();
        chk("restart_rpage_pulses", 16'(rs_cnt), 16'd1);
        chk("restart_wpage", 16'(bus.wpage), 16'd0);

        // Fill all four pages, then one dropped write
        bus.wpage_done = 1'b1;
        tick(4);
        bus.wpage_done = 1'b0;
        chk("fill_ready", 16'(bus.pages_ready), 16'd4);
        chk("fill_full", 16'(bus.buf_full), 16'd1);
        chk("fill_wpage", 16'(bus.wpage), 16'd0);
        bus.wpage_done = 1'b1;
        tick();
        bus.wpage_done = 1'b0;
        chk("drop_ready", 16'(bus.pages_ready), 16'd4);
        chk("drop_wpage", 16'(bus.wpage), 16'd0);
        chk("drop_ovf", 16'(bus.wbuf_ovf), 16'(OVF));

        // Write landing in the DONE cycle with two pages pending
        xfer_page();
        tick(2);
        xfer_page();
        tick(2);
        xfer_page();
        chk("simul_in_done", 16'(bus.page_next), 16'd1);
        chk("simul_ready_before", 16'(bus.pages_ready), 16'd2);
        bus.wpage_done = 1'b1;
        tick();
        bus.wpage_done = 1'b0;
        chk("simul_ready_after", 16'(bus.pages_ready), 16'd2);
        chk("simul_wpage", 16'(bus.wpage), 16'd1);

        // Abort after 50 words
        tick();
        bus.xfer_grant = 1'b1;
        tick();
        bus.xfer_grant = 1'b0;
        clr_cnt();
        bus.xfer_rd = 1'b1;
        tick(50);
        bus.xfer_rd = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        bus.xfer_rd = 1'b1;
        chk("abort_ready", 16'(bus.pages_ready), 16'd0);
        chk("abort_busy", 16'(bus.xfer_busy), 16'd0);
        chk("abort_rpage_set", 16'(bus.rpage_set), 16'd1);
        chk("abort_rpage_in", 16'(bus.rpage_in), 16'd0);
        chk("abort_ovf", 16'(bus.wbuf_ovf), 16'd0);
        tick(5);
        bus.xfer_rd = 1'b0;
        chk("abort_rd_count", 16'(rd_cnt), 16'd50);
        chk("abort_no_done", 16'(xd_cnt), 16'd0);
        chk("abort_rpage_pulses", 16'(rs_cnt), 16'd1);

        // Back-to-back service of three pages
        bus.wpage_done = 1'b1;
        tick(3);
        bus.wpage_done = 1'b0;
        clr_cnt();
        bus.xfer_grant = 1'b1;
        bus.xfer_rd = 1'b1;
        tick(3 * (PW + 3) + 8);
        bus.xfer_grant = 1'b0;
        bus.xfer_rd = 1'b0;
        tick(2);
        chk("b2b_pulses", 16'(pn_cyc.size()), 16'd3);
        if (pn_cyc.size() == 3) begin
            chk("b2b_gap1", 16'(pn_cyc[1] - pn_cyc[0]), 16'(PW + 3));
            chk("b2b_gap2", 16'(pn_cyc[2] - pn_cyc[1]), 16'(PW + 3));
        end
        chk("b2b_rd_count", 16'(rd_cnt), 16'(3 * PW));
        chk("b2b_want_low", 16'(bus.xfer_want), 16'd0);
        chk("b2b_ready", 16'(bus.pages_ready), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mcntrl_wbuf_sched.md
# mcntrl_wbuf_sched

Page scheduler for the 4-page external-write buffer of a memory controller write channel. It tracks how many 1 KB pages the external producer has filled (producer completion arrives already synchronized to mclk), requests memory-sequencer service whenever a page is pending, and gates sequencer read strobes into the buffer's `rd`. It drives the buffer's `page_next`/`rpage_set` controls and provides back-pressure (`wpage`, `buf_full`) to the producer.

## Interface
Parameters:
- PAGE_WORDS, 128: 64-bit reads per page. Must be a power of 2, at least 2.

Ports:
- mclk  in  1  memory controller clock; the only clock.
- mrst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  pulse; restarts the channel and aborts any transfer.
- wpage_done  in  1  pulse; producer finished writing page `wpage`.
- wpage  out  2  page the producer must write next.
- buf_full  out  1  all 4 pages pending.
- pages_ready  out  3  pending page count, 0..4.
- xfer_want  out  1  request to the memory sequencer.
- xfer_grant  in  1  sequencer accepts one page transfer.
- xfer_rd  in  1  sequencer word strobe, one per 64-bit word.
- rd  out  1  to buffer `rd`.
- page_next  out  1  to buffer `page_next`.
- rpage_set  out  1  to buffer `rpage_set`.
- rpage_in  out  2  to buffer `rpage_in`; constant 0.
- xfer_busy  out  1  high in states REQ, XFER and DONE.
- xfer_done  out  1  pulse at page completion.
- wbuf_ovf  out  1  sticky overflow (see Configuration).

## Operation
- Registers: wptr[1:0], cnt[2:0], wcnt[log2(PAGE_WORDS):0], state.
- FSM states and transitions:
  - IDLE -> REQ when cnt != 0.
  - REQ drives xfer_want=1. REQ -> XFER on xfer_grant.
  - XFER: rd = xfer_rd & (wcnt < PAGE_WORDS), a combinational gate. Each rd increments wcnt. XFER -> DONE on the cycle wcnt reaches PAGE_WORDS.
  - DONE lasts one cycle and drives page_next=1 and xfer_done=1. In that cycle cnt decrements and wcnt clears. DONE -> IDLE.
- xfer_grant outside REQ is ignored. xfer_rd outside XFER, or beyond PAGE_WORDS, produces no rd and has no other effect.
- Accepted write: wpage_done while cnt<4. It increments wptr (mod 4) and cnt.
- Write and DONE in the same cycle: cnt stays unchanged and wptr still advances.
- wpage_done while cnt==4 is dropped. A DONE in the same cycle does not make room for it.
- buf_full = (cnt==4). pages_ready = cnt.
- frame_start has highest priority. It sets state to IDLE and clears cnt, wptr and wcnt, dropping any wpage_done in the same cycle. The next cycle it drives a 1-cycle rpage_set. page_next is suppressed in that cycle.
- An abort mid-XFER emits no xfer_done. Sequencer strobes after the abort are ignored.

## Timing
- Reset values: all outputs 0, state IDLE.
- cnt 0->1 after a write: xfer_want rises on the 2nd clock edge following wpage_done (one edge updates cnt, one edge enters REQ).
- Grant latency: xfer_grant at edge N puts the FSM in XFER after N, so the first rd can come in cycle N+1.
- rd has zero latency from xfer_rd. The buffer's regen delay is internal to the buffer.
- Page completion: the last rd at edge M gives page_next and xfer_done high in the following cycle (DONE, between edges M+1 and M+2). The cnt decrement is visible after edge M+2.
- Minimum cycle per page: PAGE_WORDS + 3 clocks, counting REQ, DONE and IDLE.

## Configuration
- Macro: MCNTRL_WBUF_SCHED_OVF_EN.
- Defined: a dropped wpage_done (cnt==4) sets wbuf_ovf. wbuf_ovf stays set until frame_start or reset.
- Undefined: wbuf_ovf is tied to 0 and no overflow register is built. Dropping behaviour is unchanged.

## Test plan
- Single page: reset, one wpage_done -> xfer_want high 2 cycles later. Then grant plus 128 xfer_rd strobes -> exactly 128 rd, one page_next/xfer_done pulse, pages_ready back to 0, wpage=1.
- Fill: 4 wpage_done with no grant -> pages_ready=4, buf_full=1, wpage=0. A 5th wpage_done -> pages_ready stays 4 and wbuf_ovf=1 (macro defined) or 0 (undefined).
- Simultaneous: wpage_done in the DONE cycle with cnt=2 -> cnt stays 2 and wptr advances.
- Excess strobes: 130 xfer_rd during XFER -> 128 rd. Strobes while IDLE/REQ -> no rd.
- Abort: frame_start after 50 rd -> state IDLE, pages_ready=0, one rpage_set pulse with rpage_in=0 the next cycle, no xfer_done, wbuf_ovf cleared.
- Back-to-back: 3 pages pending with continuous grant and strobes -> 3 page_next pulses spaced PAGE_WORDS+3 cycles apart, then xfer_want low.
